// File: rtl/cmos_capture_pkg.sv
// Shared types and widths for the camera capture front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmos_capture_pkg;

  localparam int PIX_CNT_W = 12;
  localparam int FRM_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_WAIT_VS = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer for slow cross-domain flags.
// Latency: 2 destination-clock cycles.
// Backpressure: none; the level is sampled every cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_d,
  output logic O_q
);

  logic meta;

  // Two back-to-back flops; only O_q may be used by downstream logic.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      meta <= RST_VAL;
      O_q  <= RST_VAL;
    end else begin
      meta <= I_d;
      O_q  <= meta;
    end
  end

endmodule

// File: rtl/cmos_capture.sv
// OV5640 capture: byte pairs -> 16-bit pixels, frame skip, line/frame size checks.
// Latency: 2 cycles from the second byte at the input register to O_de; O_vs_n equally delayed.
// Backpressure: none; the downstream frame buffer must always accept O_de.
module cmos_capture
  import cmos_capture_pkg::*;
#(
  parameter int FRAME_SKIP = 10,
  parameter int H_RES      = 1280,
  parameter int V_RES      = 720
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_cfg_done,
  input  logic                 I_vsync,
  input  logic                 I_href,
  input  logic [7:0]           I_data,
  output logic                 O_vs_n,
  output logic                 O_de,
  output logic [15:0]          O_data,
  output logic [FRM_CNT_W-1:0] O_frame_cnt,
  output logic                 O_line_err,
  output logic                 O_frame_err
);

  localparam logic [PIX_CNT_W-1:0] H_RES_C   = PIX_CNT_W'(H_RES);
  localparam logic [PIX_CNT_W-1:0] V_RES_C   = PIX_CNT_W'(V_RES);
  localparam logic [PIX_CNT_W-1:0] PIX_ONE   = PIX_CNT_W'(1);
  localparam logic [FRM_CNT_W-1:0] FRM_ONE   = FRM_CNT_W'(1);
  localparam logic [FRM_CNT_W-1:0] SKIP_LAST = FRM_CNT_W'(FRAME_SKIP - 1);

  state_t                 state;
  logic [FRM_CNT_W-1:0]   skip_cnt;

  logic                   cfg_sync;
  logic                   cfg_d1;
  logic                   vs_r;
  logic                   vs_d1;
  logic                   href_r;
  logic                   href_d1;
  logic [7:0]             data_r;

  logic                   phase;
  logic [7:0]             hi_byte;
  logic                   pix_vld;
  logic [15:0]            pix_dat;
  logic [PIX_CNT_W-1:0]   pix_cnt;
  logic [PIX_CNT_W-1:0]   line_cnt;
  logic [FRM_CNT_W-1:0]   frame_cnt;

  logic                   vs_rise;
  logic                   href_rise;
  logic                   href_fall;
  logic                   cfg_fall;
  logic                   in_run;
  logic                   frame_start;
  logic                   pair_done;

  sync_2ff #(.RST_VAL(1'b0)) u_cfg_sync (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .I_d   (I_cfg_done),
    .O_q   (cfg_sync)
  );

  assign vs_rise     = vs_r & ~vs_d1;
  assign href_rise   = href_r & ~href_d1;
  assign href_fall   = ~href_r & href_d1;
  assign cfg_fall    = cfg_d1 & ~cfg_sync;
  assign in_run      = (state == ST_RUN);
  // The vsync rise that enters RUN is the first forwarded frame start.
  assign frame_start = vs_rise & ((state == ST_WAIT_VS) | (state == ST_RUN));
  assign pair_done   = href_r & phase;
  assign O_frame_cnt = frame_cnt;

  // Input register stage plus one-cycle history for edge detection.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      vs_r    <= 1'b0;
      href_r  <= 1'b0;
      data_r  <= 8'h00;
      vs_d1   <= 1'b0;
      href_d1 <= 1'b0;
      cfg_d1  <= 1'b0;
    end else begin
      vs_r    <= I_vsync;
      href_r  <= I_href;
      data_r  <= I_data;
      vs_d1   <= vs_r;
      href_d1 <= href_r;
      cfg_d1  <= cfg_sync;
    end
  end

  // Sequencer: wait for configuration, drop FRAME_SKIP frames, then align to a frame start.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else if (cfg_fall) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          skip_cnt <= '0;
          if (cfg_sync) state <= (FRAME_SKIP == 0) ? ST_WAIT_VS : ST_SKIP;
        end
        ST_SKIP: begin
          if (vs_rise) begin
            if (skip_cnt == SKIP_LAST) begin
              state    <= ST_WAIT_VS;
              skip_cnt <= '0;
            end else begin
              skip_cnt <= skip_cnt + FRM_ONE;
            end
          end
        end
        ST_WAIT_VS: begin
          if (vs_rise) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Byte pairing: even phase latches the high byte, odd phase completes a pixel.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      phase   <= 1'b0;
      hi_byte <= 8'h00;
      pix_vld <= 1'b0;
      pix_dat <= 16'h0000;
      pix_cnt <= '0;
    end else begin
      phase   <= href_r ? ~phase : 1'b0;
      pix_vld <= pair_done & in_run;
      if (href_r && !phase) hi_byte <= data_r;
      if (pair_done)        pix_dat <= {hi_byte, data_r};
      if (href_rise) begin
        pix_cnt <= '0;
      end else if (pair_done && (pix_cnt != '1)) begin
        pix_cnt <= pix_cnt + PIX_ONE;
      end
    end
  end

  // Output stage: sync and data leave together, blanked outside RUN.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      O_de   <= 1'b0;
      O_data <= 16'h0000;
      O_vs_n <= 1'b1;
    end else begin
      O_de   <= pix_vld;
      if (pix_vld) O_data <= pix_dat;
      O_vs_n <= in_run ? ~vs_d1 : 1'b1;
    end
  end

  // Geometry checks; a frame start wins over a line check landing in the same cycle.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      line_cnt    <= '0;
      frame_cnt   <= '0;
      O_line_err  <= 1'b0;
      O_frame_err <= 1'b0;
    end else if (frame_start) begin
      // Only a frame that began inside RUN has a trustworthy line count.
      O_frame_err <= in_run && (line_cnt != V_RES_C);
      O_line_err  <= 1'b0;
      line_cnt    <= '0;
      frame_cnt   <= frame_cnt + FRM_ONE;
    end else if (href_fall && in_run) begin
      if ((pix_cnt != H_RES_C) || phase) O_line_err <= 1'b1;
      if (line_cnt != '1) line_cnt <= line_cnt + PIX_ONE;
    end
  end

endmodule

// File: tb/tb_cmos_capture.sv
// Directed bench for cmos_capture with a pixel scoreboard.
// Latency: expects each pixel exactly 3 bench cycles after its second byte is driven.
// Backpressure: none; every O_de is consumed.
module tb_cmos_capture;

  logic        I_clk;
  logic        I_rst;
  logic        I_cfg_done;
  logic        I_vsync;
  logic        I_href;
  logic [7:0]  I_data;
  logic        O_vs_n;
  logic        O_de;
  logic [15:0] O_data;
  logic [15:0] O_frame_cnt;
  logic        O_line_err;
  logic        O_frame_err;

  typedef struct {
    logic [15:0] dat;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   de_cnt   = 0;
  bit   exp_run  = 1'b0;
  logic prev_de  = 1'b0;

  cmos_capture #(
    .FRAME_SKIP (2),
    .H_RES      (4),
    .V_RES      (4)
  ) dut (
    .I_clk       (I_clk),
    .I_rst       (I_rst),
    .I_cfg_done  (I_cfg_done),
    .I_vsync     (I_vsync),
    .I_href      (I_href),
    .I_data      (I_data),
    .O_vs_n      (O_vs_n),
    .O_de        (O_de),
    .O_data      (O_data),
    .O_frame_cnt (O_frame_cnt),
    .O_line_err  (O_line_err),
    .O_frame_err (O_frame_err)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  always @(posedge I_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every O_de must match the oldest expected pixel, data and cycle.
  always @(negedge I_clk) begin
    exp_t e;
    if (O_de === 1'b1) begin
      chk("de_back_to_back", {31'd0, prev_de}, 0);
      chk("de_expected", {31'd0, q.size() != 0}, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pix_data", {16'd0, O_data}, {16'd0, e.dat});
        chk("pix_cycle", cyc, e.due);
      end
      de_cnt++;
    end else if (q.size() != 0 && cyc > q[0].due) begin
      chk("pix_missing", {31'd0, O_de}, 1);
      void'(q.pop_front());
    end
    prev_de = O_de;
  end

  task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] b;
    logic [7:0] hi;
    exp_t       e;
    hi = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      b = (i == 0) ? b0 : (i == 1) ? b1 : 8'($urandom_range(0, 255));
      @(negedge I_clk);
      I_href = 1'b1;
      I_data = b;
      if (i[0] == 1'b0) begin
        hi = b;
      end else if (exp_run) begin
        e.dat = {hi, b};
        e.due = cyc + 3;
        q.push_back(e);
      end
    end
    @(negedge I_clk);
    I_href = 1'b0;
    I_data = 8'h00;
    repeat (6) @(negedge I_clk);
  endtask

  task automatic send_lines(input int n);
    for (int l = 0; l < n; l++) send_line(8, 8'($urandom), 8'($urandom));
  endtask

  task automatic send_vsync();
    @(negedge I_clk);
    chk("vs_n_idle", {31'd0, O_vs_n}, 1);
    I_vsync = 1'b1;
    repeat (3) @(negedge I_clk);
    chk("vs_n_pulse", {31'd0, O_vs_n}, exp_run ? 0 : 1);
    I_vsync = 1'b0;
    repeat (4) @(negedge I_clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_vs_n"},  {31'd0, O_vs_n}, 1);
    chk({tag, "_de"},    {31'd0, O_de}, 0);
    chk({tag, "_data"},  {16'd0, O_data}, 0);
    chk({tag, "_fcnt"},  {16'd0, O_frame_cnt}, 0);
    chk({tag, "_lerr"},  {31'd0, O_line_err}, 0);
    chk({tag, "_ferr"},  {31'd0, O_frame_err}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0;
    logic [7:0] hi;
    exp_t e;

    I_rst      = 1'b1;
    I_cfg_done = 1'b0;
    I_vsync    = 1'b0;
    I_href     = 1'b0;
    I_data     = 8'h00;
    repeat (3) @(negedge I_clk);
    chk_reset_outputs("reset");
    I_rst      = 1'b0;
    I_cfg_done = 1'b1;
    repeat (6) @(negedge I_clk);

    // Two skipped frames: no pixels, no sync.
    d0 = de_cnt;
    repeat (2) begin
      send_vsync();
      send_lines(4);
    end
    chk("skip_no_de", de_cnt - d0, 0);

    // First forwarded frame, first pixel 0x1234.
    exp_run = 1'b1;
    d0 = de_cnt;
    send_vsync();
    chk("fcnt_first", {16'd0, O_frame_cnt}, 1);
    send_line(8, 8'h12, 8'h34);
    send_lines(3);
    chk("frame3_de_count", de_cnt - d0, 16);
    chk("frame3_lerr", {31'd0, O_line_err}, 0);

    // Full-height frame whose last line has an odd byte count.
    send_vsync();
    chk("frame4_fcnt", {16'd0, O_frame_cnt}, 2);
    chk("frame4_ferr", {31'd0, O_frame_err}, 0);
    send_lines(3);
    chk("frame4_lerr_before", {31'd0, O_line_err}, 0);
    d0 = de_cnt;
    send_line(7, 8'($urandom), 8'($urandom));
    chk("odd_line_de_count", de_cnt - d0, 3);
    chk("odd_line_lerr", {31'd0, O_line_err}, 1);

    // Next frame start clears the line error; this frame is one line short.
    send_vsync();
    chk("frame5_lerr_cleared", {31'd0, O_line_err}, 0);
    chk("frame5_ferr", {31'd0, O_frame_err}, 0);
    chk("frame5_fcnt", {16'd0, O_frame_cnt}, 3);
    send_lines(3);

    send_vsync();
    chk("short_frame_ferr", {31'd0, O_frame_err}, 1);
    chk("frame6_fcnt", {16'd0, O_frame_cnt}, 4);
    send_lines(4);
    chk("ferr_sticky", {31'd0, O_frame_err}, 1);

    send_vsync();
    chk("frame7_ferr_cleared", {31'd0, O_frame_err}, 0);
    chk("frame7_lerr", {31'd0, O_line_err}, 0);

    // Reset in the middle of a line.
    hi = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge I_clk);
      I_href = 1'b1;
      I_data = 8'(8'h40 + i);
      if (i[0] == 1'b0) begin
        hi = I_data;
      end else begin
        e.dat = {hi, I_data};
        e.due = cyc + 3;
        q.push_back(e);
      end
    end
    @(posedge I_clk);
    #2;
    I_rst   = 1'b1;
    exp_run = 1'b0;
    q.delete();
    @(negedge I_clk);
    chk_reset_outputs("midline_reset");
    I_href = 1'b0;
    I_data = 8'h00;
    repeat (2) @(negedge I_clk);
    I_rst = 1'b0;
    repeat (6) @(negedge I_clk);

    d0 = de_cnt;
    repeat (2) begin
      send_vsync();
      send_lines(4);
    end
    chk("post_reset_skip_no_de", de_cnt - d0, 0);

    exp_run = 1'b1;
    send_vsync();
    chk("post_reset_fcnt", {16'd0, O_frame_cnt}, 1);
    send_lines(4);
    chk("post_reset_de_count", de_cnt - d0, 16);

    // Frame counter wrap.
    force dut.frame_cnt = 16'hFFFF;
    @(negedge I_clk);
    release dut.frame_cnt;
    send_vsync();
    chk("fcnt_wrap", {16'd0, O_frame_cnt}, 0);
    chk("wrap_frame_ferr", {31'd0, O_frame_err}, 0);

    repeat (4) @(negedge I_clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmos_capture.md
# cmos_capture

Capture front end between the OV5640 parallel bus and the video frame buffer write port. It assembles byte pairs into 16-bit pixels and discards the first frames after sensor configuration. It checks the line length (pixels per line) and the frame height (lines per frame), and presents a clean negative-polarity vsync, data-enable and pixel stream to the buffer's video-input port. Everything runs in the camera pixel-clock domain.

## Interface
Parameters:
- FRAME_SKIP, 10, frames discarded after I_cfg_done before output starts (0 = no skip)
- H_RES, 1280, expected pixels per line
- V_RES, 720, expected lines per frame

Ports:
- I_clk  in  1  camera pixel clock (cmos_pclk)
- I_rst  in  1  asynchronous, active-high reset
- I_cfg_done  in  1  SCCB configuration complete; asynchronous to I_clk
- I_vsync  in  1  camera vsync, active high
- I_href  in  1  camera line-valid
- I_data  in  8  camera data byte
- O_vs_n  out  1  frame sync to buffer, active low
- O_de  out  1  pixel valid, one cycle per pixel
- O_data  out  16  pixel, first byte in [15:8]
- O_frame_cnt  out  16  frames forwarded since reset, wraps
- O_line_err  out  1  sticky line-length error; cleared at frame start
- O_frame_err  out  1  sticky frame-height error; cleared at frame start

## Operation
- I_cfg_done passes through a 2-FF synchronizer.
- I_vsync, I_href and I_data are registered once (input stage) before use.
- Vsync rise: a rising edge of the registered vsync.
- FSM states: IDLE, SKIP, WAIT_VS, RUN.
  - IDLE → SKIP when the synchronized cfg_done is high. Goes straight to WAIT_VS if FRAME_SKIP=0.
  - SKIP counts vsync rises. After the FRAME_SKIP-th rise → WAIT_VS.
  - WAIT_VS → RUN on the next vsync rise.
  - Falling synchronized cfg_done in any state → IDLE.
  - RUN is left only via reset or cfg_done falling.
- Byte phase:
  - Toggles on every cycle the registered href is high.
  - Forced to 0 while href is low.
  - Phase 0 byte is latched as the high byte. The phase 1 byte completes the pixel.
- O_de is emitted only in RUN, and only for complete pairs.
- Pixel counter: 12-bit, saturating at 4095. Incremented per completed pair; reset on href rise.
- On href fall in RUN, set O_line_err if either holds:
  - pixel count ≠ H_RES;
  - phase = 1 (odd byte; the orphan byte is dropped).
- Line counter: 12-bit, saturating. Incremented on each href fall in RUN.
- On vsync rise in RUN:
  - set O_frame_err if line count ≠ V_RES, and only when a full frame has been observed in RUN;
  - then clear the line counter and both error flags;
  - increment O_frame_cnt, mod 2^16.
  - Same-cycle evaluate-then-clear: the vsync rise clears the flags, and a check firing in the same cycle is lost.
- O_vs_n = ~registered vsync in RUN, else 1.
- Reset mid-frame: all state returns to reset values immediately. Resuming output requires a new cfg_done plus skip sequence.

## Timing
- Reset values: FSM=IDLE, O_vs_n=1, O_de=0, O_data=0, O_frame_cnt=0, O_line_err=0, O_frame_err=0, all counters 0.
- Latency: second byte on I_data at edge k → O_de=1 with the pixel in O_data after edge k+2. O_de is high for exactly one cycle.
- O_vs_n is delayed by the same 2 cycles as O_de, so sync and data stay aligned.
- Pixel throughput: one pixel every 2 cycles at most. O_de is never high on consecutive cycles.
- The cycle that completes a pixel on the href-falling cycle is still emitted.
- O_data holds its last value when O_de=0.
- No backpressure: the buffer input FIFO is assumed non-full. A full FIFO is not sensed.
- cfg_done takes effect 2 cycles after it is sampled high.

## Structure
- Shared package `cmos_capture_pkg`:
  - FSM state enum;
  - counter widths (PIX_CNT_W=12, FRM_CNT_W=16).
- One sub-module: `sync_2ff`, a generic 2-flop bit synchronizer, reused for other cross-domain flags.
- All other logic is flat in cmos_capture.

## Test plan
- FRAME_SKIP=2, 3 frames of 4 lines × 8 bytes, H_RES=4, V_RES=4, cfg_done high → no O_de during frames 1–2; frame 3 emits 16 O_de pulses; O_frame_cnt increments 0→1 at the first vsync rise in RUN (start of frame 3).
- Bytes 0x12,0x34 on a line in RUN → O_de two cycles after 0x34 is presented, with O_data=0x1234.
- One line of 7 bytes → O_line_err=1 after that href fall; only 3 pixels are emitted; the next vsync rise clears the flag.
- Frame of 3 lines with V_RES=4 → O_frame_err=1 on the following vsync rise, with flags cleared afterwards per the evaluate-then-clear rule (check the flag before the clear).
- I_rst pulsed mid-line in RUN → outputs at reset values on the next edge; no O_de until cfg_done is re-seen and FRAME_SKIP frames pass.
- O_frame_cnt forced near 0xFFFF (force the counter) → wraps to 0x0000 on the next frame start.
